// File: rtl/multiword_add_sequencer.sv
// Wide adder controller: feeds one external N-bit ripple-carry slice LSB first and
// chains the slice carry. Optional SEQ_SUB_MODE_EN adds a 'sub' port for A - B.
module multiword_add_sequencer #(
  parameter int N      = 4,
  parameter int SLICES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N*SLICES-1:0] op_a,
  input  logic [N*SLICES-1:0] op_b,
  input  logic                cin,
`ifdef SEQ_SUB_MODE_EN
  input  logic                sub,
`endif
  output logic [N-1:0]        add_a,
  output logic [N-1:0]        add_b,
  output logic                add_cin,
  input  logic [N-1:0]        add_sum,
  input  logic                add_cout,
  output logic [N*SLICES-1:0] result,
  output logic                cout,
  output logic                busy,
  output logic                done
);

  localparam int W  = N * SLICES;
  localparam int IW = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IW-1:0] LAST = IW'(SLICES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  result_q, result_d;
  logic          cout_q, cout_d;
  logic          sub_q, sub_d;
  logic          sub_in;

`ifdef SEQ_SUB_MODE_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
    sub_d    = sub_q;
    add_a    = '0;
    add_b    = '0;
    add_cin  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          sub_d   = sub_in;
          // Subtract is A + ~B + 1, so the initial carry is forced high.
          carry_d = sub_in ? 1'b1 : cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        add_a   = a_q[idx_q*N +: N];
        add_b   = b_q[idx_q*N +: N] ^ {N{sub_q}};
        add_cin = carry_q;
        result_d[idx_q*N +: N] = add_sum;
        carry_d = add_cout;
        idx_d   = idx_q + IW'(1);
        if (idx_q == LAST) begin
          cout_d  = add_cout;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      sub_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      sub_q    <= sub_d;
    end
  end

  assign result = result_q;
  assign cout   = cout_q;
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);

endmodule

// File: doc/multiword_add_sequencer.md
Name: multiword_add_sequencer

Overview:
- Multi-cycle wide adder controller that reuses one external N-bit ripple-carry adder slice to add two W = N*SLICES-bit operands.
- Drives the slice adder's a/b/cin inputs one N-bit slice per cycle, LSB first, and consumes its sum/cout.
- Chains each slice's cout into the next slice's cin and assembles the full-width result.
- Sits directly around the combinational ripple-carry adder: upstream (operand feed) and downstream (result capture).

Parameters:
- N, 4, width of the external adder slice in bits.
- SLICES, 4, number of slices per operation; W = N*SLICES (default 16).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- op_a  input  W  operand A, latched on accepted start.
- op_b  input  W  operand B, latched on accepted start.
- cin  input  1  carry-in to slice 0, latched on accepted start.
- add_a  output  N  to slice adder a.
- add_b  output  N  to slice adder b.
- add_cin  output  1  to slice adder cin.
- add_sum  input  N  from slice adder sum (combinational, same cycle).
- add_cout  input  1  from slice adder cout (combinational, same cycle).
- result  output  W  assembled sum; held until the next accepted start.
- cout  output  1  carry-out of the last slice; held with result.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; result and cout valid.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. rst has priority over all other inputs.
- Reset values:
  - state=IDLE, idx=0, carry register=0.
  - result=0, cout=0, done=0, busy=0.
  - add_a=0, add_b=0, add_cin=0.
- State machine:
  - IDLE: when start=1 at an edge, latch op_a, op_b, cin into the carry register; set idx=0; go to RUN. When start=0, stay in IDLE.
  - RUN, combinational outputs: add_a=a_reg[idx*N +: N], add_b=b_reg[idx*N +: N], add_cin=carry register.
  - RUN, at each edge: result[idx*N +: N] <= add_sum; carry <= add_cout; idx <= idx+1. At the edge where idx==SLICES-1, also set cout <= add_cout and go to DONE.
  - DONE: done=1 for exactly this cycle; go to IDLE unconditionally.
- Outputs outside RUN: add_a, add_b and add_cin are driven 0.
- Latency:
  - Start accepted at edge E0; slices are captured at edges E1..E_SLICES.
  - done is high in the cycle after E_SLICES, i.e. SLICES+1 cycles after the start edge (5 cycles at default).
  - Throughput: one operation per SLICES+2 cycles.
- Start handling: start in RUN or DONE is ignored, not queued. op_a, op_b and cin changing after acceptance have no effect.
- Result visibility: result bits of completed slices update progressively during RUN. Software and downstream logic use result only when done=1 or in IDLE afterwards.
- cout: holds its previous value until the final slice edge.
- Wrap-around: the W-bit sum wraps modulo 2^W; the carry out is reported only on cout.
- Reset mid-operation: next state is IDLE with all reset values; no done pulse; the partial result is cleared.
- SLICES=1: RUN lasts one cycle and the block behaves as a registered N-bit adder.

Optional Feature:
- Macro SEQ_SUB_MODE_EN defined:
  - Adds input port sub (1 bit), latched on accepted start.
  - When sub=1: add_b = ~b_reg slice, and the initial carry is forced to 1 (cin ignored), giving result = op_a - op_b mod 2^W.
  - In this mode cout=1 means no borrow.
  - When sub=0: identical to normal add.
- Macro undefined: no sub port; add only; behaviour exactly as above.

Test Plan:
- Reset: hold rst=1 for 2 cycles with start=1 -> busy=0, done=0, result=0x0000, cout=0; add_a, add_b, add_cin all 0.
- Basic add: op_a=0x0003, op_b=0x0005, cin=0, start for 1 cycle -> busy high for 5 cycles; done pulses 5 cycles after the start edge; result=0x0008, cout=0.
- Full carry ripple: op_a=0xFFFF, op_b=0x0001, cin=0 -> add_cin=1 on slices 1..3; result=0x0000, cout=1.
- Max with carry-in: op_a=0xFFFF, op_b=0xFFFF, cin=1 -> result=0xFFFF, cout=1. Then start with 0x1234+0x0000 asserted during RUN and DONE -> ignored; result stays 0xFFFF until a new start is issued in IDLE.
- Reset mid-op: start 0xA5A5+0x5A5A, assert rst after 2 RUN edges -> IDLE next edge, result=0x0000, no done pulse. A following start of 0x0A0A+0x0606 gives result=0x1010, cout=0.
- SEQ_SUB_MODE_EN build: sub=1, op_a=0x0005, op_b=0x0007 -> result=0xFFFE, cout=0. Then sub=1, op_a=0x0010, op_b=0x0001 -> result=0x000F, cout=1.
